jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment solver; owns the 8x8 worker/job cost matrix.
- Accepts a 64-entry byte stream through a valid/ready handshake, in row-major order (worker W, job J; index W*8+J).
- Serves combinational random-access reads on W/J → Cost to the downstream solver.
- Also publishes a load-time lower bound: the sum of the per-worker row minima. The solver uses it as a sanity and pruning reference.

Parameters:
- N, 8, matrix dimension (workers = jobs = N). Only 8 is supported; the parameter exists for constants only.
- CW, 7, cost width in bits.

Ports:
- CLK input 1 system clock; all state updates on the rising edge.
- RST input 1 synchronous active-high reset.
- in_valid input 1 stream word present.
- in_ready output 1 table accepts a word this cycle.
- in_data input CW cost word.
- in_last input 1 marks the final word of a matrix.
- clear input 1 discard the table and return to IDLE (synchronous).
- W input 3 worker index for lookup.
- J input 3 job index for lookup.
- Cost output CW cost[W][J], combinational from the storage array.
- table_ready output 1 full matrix loaded and consistent.
- load_error output 1 framing error latched.
- lower_bound output 10 sum of the eight row minima (max 8*127 = 1016).
- total_sum output 13 sum of all 64 entries (max 8128).

Behaviour:
- Reset is synchronous on RST=1 at the rising CLK edge and has priority over everything. Reset values:
  - state=IDLE, wr_idx=0, row_min=all-ones, lower_bound=0, total_sum=0, table_ready=0, load_error=0, in_ready=0.
  - Storage contents are not reset; Cost is don't-care until table_ready=1.
- State machine:
  - IDLE: in_ready=0. Moves to LOAD on the next cycle, with wr_idx=0, sums cleared and row_min=127.
  - LOAD: in_ready=1. On in_valid&&in_ready:
    - Write in_data to entry wr_idx.
    - total_sum += in_data.
    - row_min = min(row_min, in_data).
    - wr_idx increments.
    - At a row end (wr_idx[2:0]==7), add the final row minimum including the current word to lower_bound, then reset row_min to 127.
  - LOAD → READY: handshake on wr_idx==63 with in_last=1. table_ready=1 from the next cycle; lower_bound and total_sum are final in that same cycle.
  - LOAD → ERROR:
    - in_last=1 on wr_idx<63, or in_last=0 on wr_idx==63.
    - The erroneous word is still written. load_error=1 next cycle, table_ready stays 0.
  - READY: in_ready=0; the table is frozen; any further in_valid is ignored (not accepted).
  - ERROR: in_ready=0; only clear or RST leaves this state.
- clear:
  - In any state, clear=1 moves to IDLE next cycle and drops table_ready and load_error.
  - clear has priority over a simultaneous handshake; that word is not accepted.
- Lookup:
  - Cost = mem[W*8+J], purely combinational, zero latency.
  - Valid for the solver's same-edge sampling. W/J may change every cycle.
  - A read of the entry being written in the same cycle returns the old value.
- Arithmetic: all sums are unsigned and sized as listed, so no overflow is possible; row_min is compared unsigned.
- Reset mid-LOAD: abandons the partial matrix; the upstream source must restart from index 0.

Decomposition:
- Shared package jam_pkg:
  - N, CW, IDX_W=6, SUM_W=13, LB_W=10.
  - State enum {IDLE, LOAD, READY, ERROR}.
  - Helper function idx(w, j) = w*8+j.
- One natural sub-module, jam_row_min: accumulates the running minimum and the row-end lower-bound addition.
- Storage array and FSM stay in the top.

Test Plan:
- Load identity-like matrix: cost[w][j]=10 when j==w, else 50, 64 words, in_last on word 64. Required:
  - table_ready=1 one cycle after the last handshake.
  - lower_bound=80, total_sum=10*8+50*56=2880.
  - Cost(W=3,J=3)=10, Cost(W=3,J=4)=50.
- Backpressure/gaps: same stream with in_valid deasserted on random cycles. Required: identical final contents, lower_bound and total_sum; exactly 64 handshakes counted.
- Early in_last on word 10 (wr_idx=9). Required:
  - load_error=1 next cycle, table_ready=0, in_ready=0.
  - After clear plus a full reload: load_error=0 and table_ready=1.
- Missing in_last on word 64. Required: load_error=1 and table_ready=0.
- Extra words after READY (in_valid=1, data=127). Required: in_ready=0 and the contents unchanged; verify via a sweep of all 64 W/J lookups.
- RST asserted at word 30, then a full reload of all-127 data. Required: lower_bound=1016, total_sum=8128, and a correct matrix sweep.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants, state type and index helper for the job-assignment cost table.
package jam_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned CW    = 7;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned SUM_W = 13;
    localparam int unsigned LB_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY,
        ERROR
    } state_t;

    function automatic logic [IDX_W-1:0] idx(input logic [2:0] w, input logic [2:0] j);
        return IDX_W'(w) * IDX_W'(N) + IDX_W'(j);
    endfunction

endpackage

// File: rtl/jam_row_min.sv
// Running per-row minimum; folds each completed row minimum into the lower bound.
module jam_row_min import jam_pkg::*; (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_init,
    input  logic            i_accept,
    input  logic [CW-1:0]   i_data,
    input  logic            i_row_end,
    output logic [LB_W-1:0] o_lower_bound
);

    logic [CW-1:0]   r_row_min;
    logic [LB_W-1:0] r_lower_bound;
    logic [CW-1:0]   w_min_now;

    // Minimum including the word being accepted this cycle
    assign w_min_now = (i_data < r_row_min) ? i_data : r_row_min;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            r_row_min     <= '1;
            r_lower_bound <= '0;
        end else if (i_accept) begin
            if (i_row_end) begin
                r_lower_bound <= r_lower_bound + LB_W'(w_min_now);
                r_row_min     <= '1;
            end else begin
                r_row_min <= w_min_now;
            end
        end
    end

    assign o_lower_bound = r_lower_bound;

endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost matrix loaded from a framed valid/ready stream, with combinational
// lookup, total sum and row-minimum lower bound for the downstream solver.
module jam_cost_table import jam_pkg::*; #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 7
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    input  logic          in_last,
    input  logic          clear,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    output logic          table_ready,
    output logic          load_error,
    output logic [9:0]    lower_bound,
    output logic [12:0]   total_sum
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [SUM_W-1:0]  r_total_sum;
    logic              r_table_ready;
    logic              r_load_error;
    logic              r_in_ready;
    logic [CW-1:0]     r_mem [N*N];

    logic              w_accept;
    logic              w_last_word;
    logic              w_row_end;
    logic              w_init;
    logic [LB_W-1:0]   w_lower_bound;

    // clear and reset both block the handshake even though in_ready is high
    assign w_accept    = in_valid && r_in_ready && !clear && !RST;
    assign w_last_word = (r_wr_idx == LAST_IDX);
    assign w_row_end   = (r_wr_idx[2:0] == 3'd7);
    assign w_init      = (r_state == IDLE);

    jam_row_min u_row_min (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_init        (w_init),
        .i_accept      (w_accept),
        .i_data        (in_data),
        .i_row_end     (w_row_end),
        .o_lower_bound (w_lower_bound)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_wr_idx      <= '0;
            r_total_sum   <= '0;
            r_table_ready <= 1'b0;
            r_load_error  <= 1'b0;
            r_in_ready    <= 1'b0;
        end else if (clear) begin
            r_state       <= IDLE;
            r_table_ready <= 1'b0;
            r_load_error  <= 1'b0;
            r_in_ready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= LOAD;
                    r_in_ready  <= 1'b1;
                    r_wr_idx    <= '0;
                    r_total_sum <= '0;
                end
                LOAD: begin
                    if (w_accept) begin
                        r_total_sum <= r_total_sum + SUM_W'(in_data);
                        r_wr_idx    <= r_wr_idx + IDX_W'(1);
                        if (w_last_word && in_last) begin
                            r_state       <= READY;
                            r_table_ready <= 1'b1;
                            r_in_ready    <= 1'b0;
                        end else if (w_last_word || in_last) begin
                            r_state      <= ERROR;
                            r_load_error <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end
                    end
                end
                READY: r_in_ready <= 1'b0;
                ERROR: r_in_ready <= 1'b0;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[r_wr_idx] <= in_data;
        end
    end

    assign Cost        = r_mem[idx(W, J)];
    assign in_ready    = r_in_ready;
    assign table_ready = r_table_ready;
    assign load_error  = r_load_error;
    assign lower_bound = w_lower_bound;
    assign total_sum   = r_total_sum;

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed-plus-random bench for jam_cost_table against an array-based matrix model.
module tb_jam_cost_table;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        in_last;
    logic        clear;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        table_ready;
    logic        load_error;
    logic [9:0]  lower_bound;
    logic [12:0] total_sum;

    int vectors    = 0;
    int miscompares = 0;
    int hs;
    logic [6:0] stim    [64];
    logic [6:0] exp_mem [64];

    always #5 CLK = ~CLK;

    jam_cost_table #(.N(8), .CW(7)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .clear       (clear),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .load_error  (load_error),
        .lower_bound (lower_bound),
        .total_sum   (total_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_lb();
        int s = 0;
        for (int w = 0; w < 8; w++) begin
            int m = 127;
            for (int j = 0; j < 8; j++)
                if (int'(exp_mem[w*8+j]) < m) m = int'(exp_mem[w*8+j]);
            s += m;
        end
        return s;
    endfunction

    function automatic int ref_total();
        int s = 0;
        for (int i = 0; i < 64; i++) s += int'(exp_mem[i]);
        return s;
    endfunction

    task automatic wait_in_ready();
        int c = 0;
        while (!in_ready && c < 20) begin
            @(negedge CLK);
            c++;
        end
        check("wait_in_ready", in_ready, 1);
    endtask

    // Streams words 0..n-1 of stim; handshakes are predicted from in_ready at the negedge
    task automatic send(input int n, input int early, input bit omit_last, input int gap_pct);
        int k = 0;
        int cyc = 0;
        bit v;
        while (k < n && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? stim[k] : 7'($urandom);
            in_last  = (k == early) || (k == 63 && !omit_last);
            if (v && in_ready) begin
                exp_mem[k] = stim[k];
                k++;
                hs++;
            end
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("send_count", k, n);
    endtask

    task automatic lookup(input string tag, input int w, input int j, input int exp);
        @(negedge CLK);
        W = 3'(w);
        J = 3'(j);
        #1;
        check(tag, Cost, exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) lookup(tag, i / 8, i % 8, int'(exp_mem[i]));
    endtask

    task automatic do_clear();
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        check("clear_table_ready", table_ready, 0);
        check("clear_load_error", load_error, 0);
    endtask

    task automatic check_loaded(input string tag);
        check({tag, "_table_ready"}, table_ready, 1);
        check({tag, "_load_error"}, load_error, 0);
        check({tag, "_lower_bound"}, lower_bound, ref_lb());
        check({tag, "_total_sum"}, total_sum, ref_total());
        check({tag, "_handshakes"}, hs, 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        clear = 1'b0; W = '0; J = '0;
        repeat (3) @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_table_ready", table_ready, 0);
        check("rst_load_error", load_error, 0);
        check("rst_lower_bound", lower_bound, 0);
        check("rst_total_sum", total_sum, 0);
        RST = 1'b0;

        // Identity-like matrix, no gaps
        wait_in_ready();
        for (int i = 0; i < 64; i++) stim[i] = ((i / 8) == (i % 8)) ? 7'd10 : 7'd50;
        hs = 0;
        send(64, -1, 1'b0, 0);
        check_loaded("ident");
        check("ident_lb_const", lower_bound, 80);
        check("ident_total_const", total_sum, 2880);
        check("ident_in_ready", in_ready, 0);
        lookup("ident_c33", 3, 3, 10);
        lookup("ident_c34", 3, 4, 50);

        // Extra words after READY are refused and leave the table intact
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_data  = 7'd127;
            in_last  = 1'($urandom);
            check("ready_in_ready", in_ready, 0);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("ready_still_ready", table_ready, 1);
        sweep("ready_frozen");

        // Same stream under random backpressure
        do_clear();
        wait_in_ready();
        hs = 0;
        send(64, -1, 1'b0, 40);
        check_loaded("gaps");
        check("gaps_lb_const", lower_bound, 80);
        check("gaps_total_const", total_sum, 2880);
        sweep("gaps_sweep");

        // Random matrices with gaps
        for (int it = 0; it < 2; it++) begin
            do_clear();
            wait_in_ready();
            for (int i = 0; i < 64; i++) stim[i] = 7'($urandom_range(127));
            hs = 0;
            send(64, -1, 1'b0, 25);
            check_loaded("rand");
            sweep("rand_sweep");
        end

        // clear wins over a simultaneous handshake
        do_clear();
        wait_in_ready();
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = ~exp_mem[0];
        in_last  = 1'b0;
        clear    = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        clear    = 1'b0;
        check("clrprio_in_ready", in_ready, 0);
        lookup("clrprio_c00", 0, 0, int'(exp_mem[0]));

        // Early in_last on word 10
        wait_in_ready();
        for (int i = 0; i < 64; i++) stim[i] = 7'($urandom_range(127));
        hs = 0;
        send(10, 9, 1'b0, 0);
        check("early_load_error", load_error, 1);
        check("early_table_ready", table_ready, 0);
        check("early_in_ready", in_ready, 0);
        lookup("early_word_written", 1, 1, int'(stim[9]));
        do_clear();
        wait_in_ready();
        hs = 0;
        send(64, -1, 1'b0, 15);
        check_loaded("reload");
        sweep("reload_sweep");

        // Missing in_last on word 64
        do_clear();
        wait_in_ready();
        for (int i = 0; i < 64; i++) stim[i] = 7'($urandom_range(127));
        hs = 0;
        send(64, -1, 1'b1, 20);
        check("nolast_load_error", load_error, 1);
        check("nolast_table_ready", table_ready, 0);
        check("nolast_in_ready", in_ready, 0);

        // Reset mid-load at word 30, then an all-127 reload
        do_clear();
        wait_in_ready();
        hs = 0;
        send(30, -1, 1'b1, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_lower_bound", lower_bound, 0);
        check("midrst_total_sum", total_sum, 0);
        RST = 1'b0;
        wait_in_ready();
        for (int i = 0; i < 64; i++) stim[i] = 7'd127;
        hs = 0;
        send(64, -1, 1'b0, 10);
        check_loaded("max");
        check("max_lb_const", lower_bound, 1016);
        check("max_total_const", total_sum, 8128);
        sweep("max_sweep");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
